// File: rtl/paralelo_serial_tx_if.sv
// paralelo_serial_tx_if: byte handshake plus serial lane bundle for paralelo_serial_tx.
// SYM_STROBE_EN adds the sym_start / sym_is_data strobes.
interface paralelo_serial_tx_if #(parameter int FIFO_DEPTH = 4);
    logic [7:0] data_in;
    logic valid_in, ready_out, data_out, active_out, com_err;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef SYM_STROBE_EN
    logic sym_start, sym_is_data;
    modport master (output data_in, valid_in,
                    input ready_out, data_out, active_out, com_err, fifo_level, sym_start, sym_is_data);
    modport slave  (input data_in, valid_in,
                    output ready_out, data_out, active_out, com_err, fifo_level, sym_start, sym_is_data);
`else
    modport master (output data_in, valid_in,
                    input ready_out, data_out, active_out, com_err, fifo_level);
    modport slave  (input data_in, valid_in,
                    output ready_out, data_out, active_out, com_err, fifo_level);
`endif
endinterface

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: FIFO-fed MSB-first byte serializer with COM training burst and COM idle fill.
// SYM_STROBE_EN adds sym_start / sym_is_data outputs.
module paralelo_serial_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int TRAIN_SYMS = 4,
    parameter logic [7:0] COM_SYM = 8'hBC
) (
    input logic clock32,
    input logic reset,
    paralelo_serial_tx_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    typedef enum logic {TRAIN, RUN} state_t;
    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] level;
    logic [2:0] bit_cnt;
    logic [3:0] train_cnt;
    logic [7:0] sym, next_sym;
    logic push, pop, wrap;
    assign wrap = bit_cnt == 3'd7;
    assign bus.ready_out = !reset && level != FULL;
    assign bus.fifo_level = level;
    assign push = bus.valid_in && bus.ready_out;
    // pop samples the registered level, so a same-edge push into an empty FIFO waits a symbol
    assign pop = state == RUN && wrap && level != '0;
    assign next_sym = pop ? mem[rd_ptr] : COM_SYM;
    always_ff @(posedge clock32) begin
        if (reset) begin
            state <= TRAIN;
            train_cnt <= 4'(TRAIN_SYMS);
            bit_cnt <= '0;
            sym <= COM_SYM;
            bus.data_out <= COM_SYM[7];
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            bus.active_out <= 1'b0;
            bus.com_err <= 1'b0;
`ifdef SYM_STROBE_EN
            bus.sym_start <= 1'b0;
            bus.sym_is_data <= 1'b0;
`endif
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            bus.data_out <= wrap ? next_sym[7] : sym[3'd6 - bit_cnt];
            if (wrap) begin
                sym <= next_sym;
                if (state == TRAIN) begin
                    train_cnt <= train_cnt - 4'd1;
                    if (train_cnt == 4'd1) begin
                        state <= RUN;
                        bus.active_out <= 1'b1;
                    end
                end
            end
            if (push) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr <= wr_ptr + 1'b1;
                if (bus.data_in == COM_SYM) bus.com_err <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (PW+1)'(push) - (PW+1)'(pop);
`ifdef SYM_STROBE_EN
            bus.sym_start <= wrap;
            bus.sym_is_data <= wrap ? pop : bus.sym_is_data;
`endif
        end
    end
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: directed bench; captures the serial lane and regroups it into 8-bit symbols.
module tb_paralelo_serial_tx;
    logic clock32 = 1'b0;
    logic reset = 1'b1;
    logic bits[$];
    int tests = 0;
    int fails = 0;
    paralelo_serial_tx_if #(.FIFO_DEPTH(4)) bus();
    paralelo_serial_tx #(.FIFO_DEPTH(4), .TRAIN_SYMS(4), .COM_SYM(8'hBC)) dut (
        .clock32(clock32),
        .reset(reset),
        .bus(bus)
    );
    always #5 clock32 = ~clock32;

    typedef struct {
        string name;
        logic [7:0] din;
        logic [7:0] exp_sym;
        logic exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clock32);
        #1;
        bits.push_back(bus.data_out);
    endtask

    task automatic run(input int n);
        repeat (n) clk1();
    endtask

    task automatic align(input int m);
        while ((bits.size() - 1) % 8 != m) clk1();
    endtask

    function automatic logic [7:0] sym_at(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = bits[b+i];
        return r;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.valid_in = 1'b0;
        repeat (n) begin
            @(posedge clock32);
            #1;
        end
        check("rst_data_out", bus.data_out, 1);
        check("rst_level", bus.fifo_level, 0);
        check("rst_ready", bus.ready_out, 0);
        check("rst_active", bus.active_out, 0);
        check("rst_com_err", bus.com_err, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", bus.ready_out, 1);
        bits.delete();
        bits.push_back(bus.data_out);
    endtask

    initial begin
        int b, s, guard;
        vecs[0] = '{"tbl_a5", 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{"tbl_00", 8'h00, 8'h00, 1'b0};
        vecs[2] = '{"tbl_ff", 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{"tbl_3c", 8'h3C, 8'h3C, 1'b0};
        vecs[4] = '{"tbl_bc", 8'hBC, 8'hBC, 1'b1};
        vecs[5] = '{"tbl_5a", 8'h5A, 8'h5A, 1'b1};
        bus.valid_in = 1'b0;
        bus.data_in = 8'h00;

        // idle after reset: training COMs then COM fill
        do_reset(2);
        run(31);
        check("train_active_lo", bus.active_out, 0);
        run(1);
        check("train_active_hi", bus.active_out, 1);
        run(15);
        for (int k = 0; k < 6; k++) check($sformatf("idle_sym%0d", k), sym_at(8*k), 8'hBC);

        // byte pushed during training waits for the first RUN load
        do_reset(2);
        bus.data_in = 8'hA5;
        bus.valid_in = 1'b1;
        clk1();
        bus.valid_in = 1'b0;
        check("a5_level_push", bus.fifo_level, 1);
        run(38);
        check("a5_level_wait", bus.fifo_level, 1);
        clk1();
        check("a5_level_pop", bus.fifo_level, 0);
        run(7);
        for (int k = 0; k < 5; k++) check($sformatf("a5_com%0d", k), sym_at(8*k), 8'hBC);
        check("a5_sym", sym_at(40), 8'hA5);

        // minimum-latency pushes in RUN, one byte per vector
        foreach (vecs[i]) begin
            align(6);
            bus.data_in = vecs[i].din;
            bus.valid_in = 1'b1;
            clk1();
            bus.valid_in = 1'b0;
            check({vecs[i].name, "_lvl1"}, bus.fifo_level, 1);
            clk1();
            check({vecs[i].name, "_lvl0"}, bus.fifo_level, 0);
            b = bits.size() - 1;
            run(7);
            check({vecs[i].name, "_sym"}, sym_at(b), vecs[i].exp_sym);
            check({vecs[i].name, "_err"}, bus.com_err, vecs[i].exp_err);
        end

        // push into empty FIFO on the boundary edge: COM first, byte next
        align(7);
        bus.data_in = 8'h66;
        bus.valid_in = 1'b1;
        clk1();
        bus.valid_in = 1'b0;
        check("edge_level", bus.fifo_level, 1);
        b = bits.size() - 1;
        run(15);
        check("edge_com", sym_at(b), 8'hBC);
        check("edge_byte", sym_at(b+8), 8'h66);
        check("edge_level0", bus.fifo_level, 0);

        // five back-to-back pushes into a 4-deep FIFO
        align(0);
        s = bits.size() - 1;
        for (int i = 1; i <= 5; i++) begin
            bus.data_in = 8'(i);
            bus.valid_in = 1'b1;
            guard = 0;
            while (!bus.ready_out && guard < 16) begin
                clk1();
                guard++;
            end
            if (guard == 16) check("burst_ready_timeout", 0, 1);
            clk1();
            if (i == 4) begin
                check("burst_full_level", bus.fifo_level, 4);
                check("burst_full_ready", bus.ready_out, 0);
            end
        end
        bus.valid_in = 1'b0;
        while (bits.size() < s + 56) clk1();
        for (int k = 0; k < 5; k++) check($sformatf("burst_sym%0d", k), sym_at(s+8+8*k), k + 1);
        check("burst_tail_com", sym_at(s+48), 8'hBC);
        check("err_sticky", bus.com_err, 1);

        // reset mid-symbol with three bytes queued
        align(0);
        bus.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 8'h11 * 8'(i + 1);
            clk1();
        end
        bus.valid_in = 1'b0;
        check("mid_level", bus.fifo_level, 3);
        clk1();
        do_reset(1);
        run(79);
        for (int k = 0; k < 10; k++) check($sformatf("mid_sym%0d", k), sym_at(8*k), 8'hBC);
        check("mid_level_end", bus.fifo_level, 0);
        check("mid_active_end", bus.active_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
